// File: rtl/cpu_defs.sv
// ----------------------------------------------------------------------------
// cpu_defs : shared encodings for the fetch controller and its CP0 slice.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_defs;

    localparam logic [31:0] VECTOR   = 32'h0000_4180;
    localparam int          NIRQ_DEF = 6;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PEND    = 3'd1,
        ST_ENTER   = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RET     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PCSEL_PC4 = 2'd0,
        PCSEL_NPC = 2'd1,
        PCSEL_RS  = 2'd2
    } pc_sel_e;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LSB    = 10;
    localparam int CAUSE_IP_LSB = 10;

endpackage

`default_nettype wire

// File: rtl/cp0_regs.sv
// ----------------------------------------------------------------------------
// cp0_regs : SR / Cause / EPC storage with mtc0 write and mfc0 read mux.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cp0_regs
    import cpu_defs::*;
#(
    parameter int NIRQ = NIRQ_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_i,
    input  logic            we_i,
    input  logic [4:0]      addr_i,
    input  logic [31:0]     wdata_i,
    input  logic            hw_enter_i,
    input  logic            hw_ret_i,
    input  logic [31:0]     pc_i,
    output logic [31:0]     rdata_o,
    output logic [NIRQ-1:0] im_o,
    output logic            ie_o,
    output logic            exl_o,
    output logic [31:0]     epc_o
);

    logic [NIRQ-1:0] im_q, im_d;
    logic [NIRQ-1:0] cause_q;
    logic            ie_q, ie_d;
    logic            exl_q, exl_d;
    logic [31:0]     epc_q, epc_d;

    logic w_sr_we;
    logic w_epc_we;

    assign w_sr_we  = we_i && (addr_i == CP0_SR);
    assign w_epc_we = we_i && (addr_i == CP0_EPC);

    // Software write first, then the hardware entry/return update overrides it.
    always_comb begin
        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
        epc_d = epc_q;
        if (w_sr_we) begin
            im_d  = wdata_i[SR_IM_LSB +: NIRQ];
            ie_d  = wdata_i[SR_IE_BIT];
            exl_d = wdata_i[SR_EXL_BIT];
        end
        if (w_epc_we) begin
            epc_d = wdata_i;
        end
        if (hw_enter_i) begin
            exl_d = 1'b1;
            epc_d = pc_i;
        end else if (hw_ret_i) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im_q    <= '0;
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            im_q    <= im_d;
            ie_q    <= ie_d;
            exl_q   <= exl_d;
            epc_q   <= epc_d;
            cause_q <= irq_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            CP0_SR: begin
                rdata_o[SR_IM_LSB +: NIRQ] = im_q;
                rdata_o[SR_EXL_BIT]        = exl_q;
                rdata_o[SR_IE_BIT]         = ie_q;
            end
            CP0_CAUSE: rdata_o[CAUSE_IP_LSB +: NIRQ] = cause_q;
            CP0_EPC:   rdata_o = epc_q;
            default:   rdata_o = '0;
        endcase
    end

    assign im_o  = im_q;
    assign ie_o  = ie_q;
    assign exl_o = exl_q;
    assign epc_o = epc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl : PC source selection, interrupt entry at safe boundaries, eret.
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl
    import cpu_defs::*;
#(
    parameter int NIRQ = NIRQ_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic            br_taken,
    input  logic            jr_taken,
    input  logic            eret_d,
    input  logic            hazard_stall,
    input  logic [31:0]     pc_f,
    input  logic            cp0_we,
    input  logic [4:0]      cp0_addr,
    input  logic [31:0]     cp0_wdata,
    output logic [31:0]     cp0_rdata,
    output logic [1:0]      PC_sel,
    output logic            Stall,
    output logic            interupt,
    output logic            int_end,
    output logic [31:0]     EPC,
    output logic            flush_fd,
    output logic            exl
);

    state_e          state_q, state_d;
    logic [NIRQ-1:0] w_im;
    logic            w_ie;
    logic            w_req;
    logic            w_safe;

    cp0_regs #(
        .NIRQ (NIRQ)
    ) u_cp0 (
        .clk        (clk),
        .rst        (rst),
        .irq_i      (irq),
        .we_i       (cp0_we),
        .addr_i     (cp0_addr),
        .wdata_i    (cp0_wdata),
        .hw_enter_i (state_q == ST_ENTER),
        .hw_ret_i   (state_q == ST_RET),
        .pc_i       (pc_f),
        .rdata_o    (cp0_rdata),
        .im_o       (w_im),
        .ie_o       (w_ie),
        .exl_o      (exl),
        .epc_o      (EPC)
    );

    assign w_req  = (|(irq & w_im)) & w_ie & ~exl;
    // Any redirect or stall in D means the F/D pair must not be split.
    assign w_safe = ~(br_taken | jr_taken | eret_d | hazard_stall);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (eret_d && exl)  state_d = ST_RET;
                else if (w_req)     state_d = w_safe ? ST_ENTER : ST_PEND;
            end
            ST_PEND: begin
                if (eret_d && exl)  state_d = ST_RET;
                else if (!w_req)    state_d = ST_RUN;
                else if (w_safe)    state_d = ST_ENTER;
            end
            ST_ENTER:   state_d = ST_HANDLER;
            ST_HANDLER: begin
                if (eret_d)         state_d = ST_RET;
            end
            ST_RET:     state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_comb begin
        PC_sel   = PCSEL_PC4;
        Stall    = 1'b0;
        interupt = 1'b0;
        int_end  = 1'b0;
        flush_fd = 1'b0;
        case (state_q)
            ST_ENTER: begin
                interupt = 1'b1;
                flush_fd = 1'b1;
            end
            ST_RET: begin
                int_end  = 1'b1;
                flush_fd = 1'b1;
            end
            default: begin
                if (eret_d)        PC_sel = PCSEL_PC4;
                else if (br_taken) PC_sel = PCSEL_NPC;
                else if (jr_taken) PC_sel = PCSEL_RS;
                Stall = hazard_stall;
            end
        endcase
        // Keep the combinational outputs quiet while reset is held.
        if (!rst) begin
            PC_sel = PCSEL_PC4;
            Stall  = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl : directed + randomized checks of fetch_ctrl against a model.
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_ctrl;

    localparam int NIRQ = 6;

    logic            clk;
    logic            rst;
    logic [NIRQ-1:0] irq;
    logic            br_taken, jr_taken, eret_d, hazard_stall;
    logic [31:0]     pc_f;
    logic            cp0_we;
    logic [4:0]      cp0_addr;
    logic [31:0]     cp0_wdata;
    logic [31:0]     cp0_rdata;
    logic [1:0]      PC_sel;
    logic            Stall, interupt, int_end, flush_fd, exl;
    logic [31:0]     EPC;

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(.NIRQ(NIRQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq          (irq),
        .br_taken     (br_taken),
        .jr_taken     (jr_taken),
        .eret_d       (eret_d),
        .hazard_stall (hazard_stall),
        .pc_f         (pc_f),
        .cp0_we       (cp0_we),
        .cp0_addr     (cp0_addr),
        .cp0_wdata    (cp0_wdata),
        .cp0_rdata    (cp0_rdata),
        .PC_sel       (PC_sel),
        .Stall        (Stall),
        .interupt     (interupt),
        .int_end      (int_end),
        .EPC          (EPC),
        .flush_fd     (flush_fd),
        .exl          (exl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: entry/return pulses, a handler flag and the CP0 contents.
    bit        m_enter, m_ret, m_inh;
    bit [5:0]  m_im, m_cause;
    bit        m_ie, m_exl;
    bit [31:0] m_epc;

    always @(posedge clk or negedge rst) begin : model_upd
        bit busy, req, safe, n_enter, n_ret;
        if (!rst) begin
            m_enter = 0; m_ret = 0; m_inh = 0;
            m_im = 0; m_cause = 0; m_ie = 0; m_exl = 0; m_epc = 0;
        end else begin
            busy    = m_enter || m_ret;
            req     = ((irq & m_im) != 0) && m_ie && !m_exl;
            safe    = !(br_taken || jr_taken || eret_d || hazard_stall);
            n_enter = !busy && !m_inh && req && safe;
            n_ret   = !busy && eret_d && (m_inh || m_exl);
            if (cp0_we && cp0_addr == 5'd12) begin
                m_im  = cp0_wdata[15:10];
                m_ie  = cp0_wdata[0];
                m_exl = cp0_wdata[1];
            end
            if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata;
            if (m_enter) begin
                m_epc = pc_f;
                m_exl = 1;
                m_inh = 1;
            end
            if (m_ret) begin
                m_exl = 0;
                m_inh = 0;
            end
            m_cause = irq;
            m_enter = n_enter;
            m_ret   = n_ret;
        end
    end

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        case (a)
            5'd12:   return {16'd0, m_im, 8'd0, m_exl, m_ie};
            5'd13:   return {16'd0, m_cause, 10'd0};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin : compare
        logic [1:0] e_sel;
        bit         busy;
        if (rst) begin
            busy  = m_enter || m_ret;
            e_sel = (busy || eret_d) ? 2'd0 : br_taken ? 2'd1 : jr_taken ? 2'd2 : 2'd0;
            chk("PC_sel",    {30'd0, PC_sel}, {30'd0, e_sel});
            chk("Stall",     {31'd0, Stall},  {31'd0, (!busy && hazard_stall)});
            chk("interupt",  {31'd0, interupt}, {31'd0, m_enter});
            chk("int_end",   {31'd0, int_end},  {31'd0, m_ret});
            chk("flush_fd",  {31'd0, flush_fd}, {31'd0, busy});
            chk("exl",       {31'd0, exl},      {31'd0, m_exl});
            chk("EPC",       EPC, m_epc);
            chk("cp0_rdata", cp0_rdata, m_rdata(cp0_addr));
            chk("pulse_excl", {31'd0, (interupt && int_end)}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        irq = '0; br_taken = 0; jr_taken = 0; eret_d = 0; hazard_stall = 0;
        cp0_we = 0; cp0_addr = 5'd12; cp0_wdata = '0;
    endtask

    initial begin
        rst  = 1'b0;
        pc_f = 32'h0000_3000;
        clear_inputs();
        br_taken = 1; hazard_stall = 1;
        #2;
        chk("rst_PC_sel", {30'd0, PC_sel}, 32'd0);
        chk("rst_Stall",  {31'd0, Stall},  32'd0);
        chk("rst_flush",  {31'd0, flush_fd}, 32'd0);
        chk("rst_sr",     cp0_rdata, 32'd0);
        tick();
        tick();
        clear_inputs();
        rst = 1'b1;

        // Straight-line entry at 0x3010.
        tick(); cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401; pc_f = 32'h3010;
        tick(); cp0_we = 0; irq = 6'b000001;
        #2; chk("sr_read", cp0_rdata, 32'h0000_0401); chk("no_early_int", {31'd0, interupt}, 32'd0);
        tick();
        #2; chk("enter_int", {31'd0, interupt}, 32'd1); chk("enter_flush", {31'd0, flush_fd}, 32'd1);
        chk("enter_stall", {31'd0, Stall}, 32'd0);
        tick(); irq = 0; cp0_addr = 5'd14;
        #2; chk("int_pulse_end", {31'd0, interupt}, 32'd0); chk("hdl_exl", {31'd0, exl}, 32'd1);
        chk("epc_3010", EPC, 32'h0000_3010); chk("epc_read", cp0_rdata, 32'h0000_3010);
        tick(); irq = 6'b000001;
        #2; chk("reraise_1", {31'd0, interupt}, 32'd0);
        tick();
        #2; chk("reraise_2", {31'd0, interupt}, 32'd0);
        tick(); irq = 0; eret_d = 1; br_taken = 1;
        #2; chk("eret_prio", {30'd0, PC_sel}, 32'd0);
        tick(); eret_d = 0; br_taken = 0;
        #2; chk("ret_int_end", {31'd0, int_end}, 32'd1); chk("ret_flush", {31'd0, flush_fd}, 32'd1);
        tick();
        #2; chk("ret_end", {31'd0, int_end}, 32'd0); chk("ret_exl", {31'd0, exl}, 32'd0);
        chk("ret_pcsel", {30'd0, PC_sel}, 32'd0);

        // Request during a taken branch is deferred past the delay slot.
        tick(); br_taken = 1; irq = 6'b000001; pc_f = 32'h3100;
        #2; chk("br_pcsel", {30'd0, PC_sel}, 32'd1); chk("br_no_int", {31'd0, interupt}, 32'd0);
        tick(); br_taken = 0; pc_f = 32'h5000;
        #2; chk("pend_no_int", {31'd0, interupt}, 32'd0);
        tick();
        #2; chk("pend_enter", {31'd0, interupt}, 32'd1);
        tick(); irq = 0;
        #2; chk("pend_epc", EPC, 32'h0000_5000); chk("pend_exl", {31'd0, exl}, 32'd1);
        tick(); eret_d = 1;
        tick(); eret_d = 0;
        tick();

        // Load-use stall holds off entry.
        tick(); hazard_stall = 1; irq = 6'b000001;
        #2; chk("hz_stall0", {31'd0, Stall}, 32'd1);
        for (int i = 1; i < 3; i++) begin
            tick();
            #2; chk("hz_stall", {31'd0, Stall}, 32'd1); chk("hz_no_int", {31'd0, interupt}, 32'd0);
        end
        tick(); hazard_stall = 0;
        #2; chk("hz_clear", {31'd0, Stall}, 32'd0); chk("hz_clear_int", {31'd0, interupt}, 32'd0);
        tick();
        #2; chk("hz_enter", {31'd0, interupt}, 32'd1);
        tick(); irq = 0;
        tick(); eret_d = 1;
        tick(); eret_d = 0;
        tick();

        // All lines masked.
        tick(); cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0001;
        tick(); cp0_we = 0; irq = 6'h3F; cp0_addr = 5'd13;
        #2; chk("mask_no_int0", {31'd0, interupt}, 32'd0);
        tick();
        #2; chk("cause_fc00", cp0_rdata, 32'h0000_FC00); chk("mask_no_int1", {31'd0, interupt}, 32'd0);
        tick();
        #2; chk("mask_exl", {31'd0, exl}, 32'd0);

        // Asynchronous reset in the middle of ENTER.
        tick(); irq = 0; cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
        tick(); cp0_we = 0; irq = 6'b000001; pc_f = 32'h6000;
        tick(); br_taken = 1; hazard_stall = 1;
        #2; chk("ar_enter", {31'd0, interupt}, 32'd1);
        rst = 1'b0;
        #1;
        chk("ar_int",   {31'd0, interupt}, 32'd0);
        chk("ar_flush", {31'd0, flush_fd}, 32'd0);
        chk("ar_pcsel", {30'd0, PC_sel}, 32'd0);
        chk("ar_stall", {31'd0, Stall}, 32'd0);
        chk("ar_exl",   {31'd0, exl}, 32'd0);
        chk("ar_sr",    cp0_rdata, 32'd0);
        chk("ar_epc",   EPC, 32'd0);
        tick(); clear_inputs(); rst = 1'b1;
        tick();

        // Randomized traffic, checked every cycle by the compare process.
        cp0_we = 1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
        for (int n = 0; n < 2000; n++) begin
            tick();
            rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) irq = 6'($urandom_range(0, 63));
            br_taken     = ($urandom_range(0, 5) == 0);
            jr_taken     = ($urandom_range(0, 7) == 0);
            eret_d       = ($urandom_range(0, 9) == 0);
            hazard_stall = ($urandom_range(0, 5) == 0);
            pc_f         = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            cp0_we       = ($urandom_range(0, 11) == 0);
            cp0_addr     = 5'($urandom_range(0, 15));
            if (cp0_we && $urandom_range(0, 1) == 0) cp0_addr = 5'd12;
            cp0_wdata    = $urandom;
        end
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
